ov7670_tx: RTL and testbench

Synthesizable OV7670 video-source emulator: the transmitting end of the camera's parallel DVP pixel bus. It accepts 12-bit RGB444 pixels over a valid/ready handshake and emits them as two bytes per pixel, with VGA-pattern VSYNC/HREF framing identical to the OV7670 output. It feeds the capture path (or any DVP receiver) in simulation and in loop-back builds, so capture and video-processing can run without a physical camera.

---
 rtl/ov7670_pkg.sv | 35 +++
 rtl/ov7670_line_timer.sv | 50 +++++
 rtl/ov7670_tx.sv | 188 ++++++++++++++++++
 tb/tb_ov7670_tx.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 DVP source emulator and its capture path:
// FSM state encoding, default VGA timing constants and RGB444 byte packing.
package ov7670_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBP    = 3'd2,
        ACTIVE = 3'd3,
        VFP    = 3'd4
    } state_e;

    localparam int DEF_DW        = 12;
    localparam int DEF_RL        = 640;
    localparam int DEF_ROW       = 480;
    localparam int DEF_HBLANK    = 288;
    localparam int DEF_VS_LINES  = 3;
    localparam int DEF_VBP_LINES = 17;
    localparam int DEF_VFP_LINES = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // RGB444 pixel -> {byte0, byte1}; byte0 carries red in its low nibble.
    function automatic logic [15:0] rgb444_pack(input logic [11:0] pix);
        return {4'h0, pix[11:8], pix[7:0]};
    endfunction

    // {byte0, byte1} -> RGB444 pixel; the upper nibble of byte0 is ignored.
    function automatic logic [11:0] rgb444_unpack(input logic [7:0] b0, input logic [7:0] b1);
        return {b0[3:0], b1};
    endfunction

endpackage

// File: rtl/ov7670_line_timer.sv
// Horizontal byte-slot counter for the DVP source. Counts 0..L-1 while the
// frame generator runs and decodes the slot classes the data path needs.
module ov7670_line_timer #(
    parameter int RL     = 640,
    parameter int HBLANK = 288
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_line_start,
    output logic o_line_end,
    output logic o_href_win,
    output logic o_even_slot,
    output logic o_odd_slot
);

    localparam int L  = 2 * RL + HBLANK;
    localparam int HW = (L > 2) ? $clog2(L) : 1;
    localparam logic [HW-1:0] LAST_SLOT = HW'(L - 1);
    localparam logic [HW:0]   ACT_SLOTS = (HW + 1)'(2 * RL);

    logic [HW-1:0] hcnt_q, hcnt_d;

    // Slot decode: first 2*RL slots of each line are the href window.
    always_comb begin
        o_line_start = (hcnt_q == '0);
        o_line_end   = (hcnt_q == LAST_SLOT);
        o_href_win   = ({1'b0, hcnt_q} < ACT_SLOTS);
        o_even_slot  = o_href_win && !hcnt_q[0];
        o_odd_slot   = o_href_win && hcnt_q[0];
    end

    // Next slot: advance while running, wrap at line end, park at 0 otherwise.
    always_comb begin
        hcnt_d = '0;
        if (i_run && !o_line_end) begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    // Slot counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end

endmodule

// File: rtl/ov7670_tx.sv
// OV7670 video-source emulator: takes RGB444 pixels and drives a free-running
// DVP byte stream with VGA-style VSYNC/HREF framing.
//
// Pixel handshake: a pixel transfers in a cycle where o_data_ready and
// i_data_valid are both high. o_data_ready is combinational and never waits
// on i_data_valid; it is high only in the cycle before each even href slot.
// If i_data_valid is low in such a cycle the slot is filled with 12'h000 and
// o_underrun latches; the stream never stalls.
//
// All framing outputs are registered from the current state/slot, so the
// output timeline trails the internal slot timeline by exactly one cycle.
module ov7670_tx
    import ov7670_pkg::*;
#(
    parameter int DW        = 12,
    parameter int RL        = 640,
    parameter int ROW       = 480,
    parameter int HBLANK    = 288,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_data_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_data_ready,
    output logic [7:0]    o_pix_byte,
    output logic          o_vsync,
    output logic          o_href,
    output logic          o_frame_done,
    output logic          o_underrun,
    output state_e        o_dbg_state
);

    generate
        if (DW != 12) begin : g_dw_check
            $error("ov7670_tx: DW must be 12 (RGB444)");
        end
    endgenerate

    localparam int MAXL = max_int(max_int(ROW, VS_LINES), max_int(VBP_LINES, VFP_LINES));
    localparam int LNW  = (MAXL > 1) ? $clog2(MAXL) : 1;

    state_e           state_q, state_d;
    logic [LNW-1:0]   line_q, line_d;
    logic [LNW-1:0]   line_last;
    logic             last_line;

    logic             line_start, line_end, href_win, even_slot, odd_slot;
    logic             in_active;

    logic [7:0]       pix_byte_q, pix_byte_d;
    logic [7:0]       low_q, low_d;
    logic             vsync_q, vsync_d;
    logic             href_q, href_d;
    logic             frame_done_q, frame_done_d;
    logic             underrun_q, underrun_d;
    logic [11:0]      pix_in;
    logic [15:0]      pix_pair;

    ov7670_line_timer #(
        .RL     (RL),
        .HBLANK (HBLANK)
    ) u_line_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_run        (state_q != IDLE),
        .o_line_start (line_start),
        .o_line_end   (line_end),
        .o_href_win   (href_win),
        .o_even_slot  (even_slot),
        .o_odd_slot   (odd_slot)
    );

    // Number of the final line of the current state.
    always_comb begin
        line_last = '0;
        case (state_q)
            VSYNC:   line_last = LNW'(VS_LINES - 1);
            VBP:     line_last = LNW'(VBP_LINES - 1);
            ACTIVE:  line_last = LNW'(ROW - 1);
            VFP:     line_last = LNW'(VFP_LINES - 1);
            default: line_last = '0;
        endcase
        last_line = (line_q == line_last);
    end

    // Frame FSM: states advance on the last slot of their last line.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                line_d = '0;
                if (i_en) begin
                    state_d = VSYNC;
                end
            end
            default: begin
                if (line_end) begin
                    if (last_line) begin
                        line_d = '0;
                        case (state_q)
                            VSYNC:   state_d = VBP;
                            VBP:     state_d = ACTIVE;
                            ACTIVE:  state_d = VFP;
                            VFP:     state_d = i_en ? VSYNC : IDLE;
                            default: state_d = IDLE;
                        endcase
                    end else begin
                        line_d = line_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // FSM state and line counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
        end
    end

    // Pixel request: one per even href slot, suppressed while reset is held.
    always_comb begin
        in_active    = (state_q == ACTIVE);
        o_data_ready = !i_rst && in_active && even_slot;
        pix_in       = (o_data_ready && i_data_valid) ? i_data : 12'h000;
        pix_pair     = rgb444_pack(pix_in);
    end

    // Output next-values: byte0 on the accepted slot, byte1 held for the odd slot.
    always_comb begin
        pix_byte_d   = 8'h00;
        low_d        = low_q;
        vsync_d      = (state_q == VSYNC);
        href_d       = in_active && href_win;
        frame_done_d = (state_q == VFP) && line_end && last_line;
        underrun_d   = underrun_q;
        if (o_data_ready) begin
            pix_byte_d = pix_pair[15:8];
            low_d      = pix_pair[7:0];
        end else if (in_active && odd_slot) begin
            pix_byte_d = low_q;
        end
        // First VSYNC slot clears the flag so it rises together with o_vsync.
        if ((state_q == VSYNC) && line_start && (line_q == '0)) begin
            underrun_d = 1'b0;
        end
        if (o_data_ready && !i_data_valid) begin
            underrun_d = 1'b1;
        end
    end

    // Registered DVP outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pix_byte_q   <= 8'h00;
            low_q        <= 8'h00;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            pix_byte_q   <= pix_byte_d;
            low_q        <= low_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign o_pix_byte   = pix_byte_q;
    assign o_vsync      = vsync_q;
    assign o_href       = href_q;
    assign o_frame_done = frame_done_q;
    assign o_underrun   = underrun_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_ov7670_tx.sv
// Bench for ov7670_tx with reduced timing (RL=4, ROW=2, HBLANK=8, 1/2/1 lines,
// L=16, 96-cycle frame). Cycle index 0 of each run is the IDLE cycle in which
// i_en is first seen high; framing outputs of frame slot k appear at index k+2.
module tb_ov7670_tx;
  import ov7670_pkg::*;

  localparam int RL     = 4;
  localparam int ROW    = 2;
  localparam int HBLANK = 8;
  localparam int VS_L   = 1;
  localparam int VBP_L  = 2;
  localparam int VFP_L  = 1;
  localparam int L      = 16;
  localparam int FRAME  = 96;
  localparam int W      = 28;
  localparam int TRN    = 512;

  logic        clk;
  logic        rst;
  logic        en;
  logic        valid;
  logic [11:0] data;
  logic        ready;
  logic [7:0]  pix_byte;
  logic        vsync;
  logic        href;
  logic        fdone;
  logic        underrun;
  state_e      dbg_state;

  ov7670_tx #(
    .DW(12), .RL(RL), .ROW(ROW), .HBLANK(HBLANK),
    .VS_LINES(VS_L), .VBP_LINES(VBP_L), .VFP_LINES(VFP_L)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data_valid(valid), .i_data(data),
    .o_data_ready(ready), .o_pix_byte(pix_byte), .o_vsync(vsync), .o_href(href),
    .o_frame_done(fdone), .o_underrun(underrun), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic [11:0] pix;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t       vecs[16];
  logic [W-1:0] exp_q[$];
  int         src_q[$];
  int         n_tests;
  int         n_fail;
  int         cyc;
  int         n_hs;
  int         starve_idx;
  logic       en_drv;
  logic       mon_phase;
  logic [7:0] mon_b0;
  int         zero_viol;

  logic       tr_vs[TRN];
  logic       tr_hr[TRN];
  logic       tr_fd[TRN];
  logic       tr_rdy[TRN];
  logic       tr_ur[TRN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver model: rebuild each pixel from the byte pair seen under href.
  task automatic rx_pixel(input logic [7:0] b0, input logic [7:0] b1);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("unexpected pixel on bus", {20'h0, b0, b1}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("byte pair", {16'h0, b0, b1}, {16'h0, e[15:0]});
      check("rebuilt pixel", {20'h0, b0[3:0], b1}, {20'h0, e[27:16]});
    end
  endtask

  // One clock cycle: drive inputs, sample all outputs, track handshakes.
  task automatic tick();
    en = en_drv;
    if (src_q.size() > 0 && n_hs != starve_idx) begin
      valid = 1'b1;
      data  = vecs[src_q[0]].pix;
    end else begin
      valid = 1'b0;
      data  = 12'h000;
    end
    #1;
    if (cyc < TRN) begin
      tr_vs[cyc]  = vsync;
      tr_hr[cyc]  = href;
      tr_fd[cyc]  = fdone;
      tr_rdy[cyc] = ready;
      tr_ur[cyc]  = underrun;
    end
    if (href === 1'b1) begin
      if (!mon_phase) begin
        mon_b0    = pix_byte;
        mon_phase = 1'b1;
      end else begin
        mon_phase = 1'b0;
        rx_pixel(mon_b0, pix_byte);
      end
    end else begin
      mon_phase = 1'b0;
      if (pix_byte !== 8'h00) zero_viol++;
    end
    if (ready === 1'b1) begin
      if (valid) begin
        exp_q.push_back({vecs[src_q[0]].pix, vecs[src_q[0]].b0, vecs[src_q[0]].b1});
        void'(src_q.pop_front());
      end else begin
        exp_q.push_back({12'h000, 8'h00, 8'h00});
      end
      n_hs++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    en_drv = 1'b0;
    en     = 1'b0;
    valid  = 1'b0;
    data   = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check("reset: vsync", {31'h0, vsync}, 0);
    check("reset: href", {31'h0, href}, 0);
    check("reset: pix_byte", {24'h0, pix_byte}, 0);
    check("reset: frame_done/underrun/ready", {29'h0, fdone, underrun, ready}, 0);
    check("reset: state", {29'h0, dbg_state}, {29'h0, IDLE});
    rst = 1'b0;
    exp_q.delete();
    src_q.delete();
    n_hs       = 0;
    starve_idx = -1;
    mon_phase  = 1'b0;
    zero_viol  = 0;
    cyc        = 0;
  endtask

  // ---------------- reference framing model (output timeline) ----------------
  function automatic logic m_vs(input int k, input int nfr);
    if (k < 0 || k >= FRAME * nfr) return 1'b0;
    return ((k % FRAME) / L) < VS_L;
  endfunction

  function automatic logic m_href(input int k, input int nfr);
    int line;
    if (k < 0 || k >= FRAME * nfr) return 1'b0;
    line = (k % FRAME) / L;
    return (line >= VS_L + VBP_L) && (line < VS_L + VBP_L + ROW) && ((k % L) < 2 * RL);
  endfunction

  function automatic logic m_fd(input int k, input int nfr);
    if (k < 0 || k >= FRAME * nfr) return 1'b0;
    return (k % FRAME) == FRAME - 1;
  endfunction

  function automatic logic m_rdy(input int k, input int nfr);
    if (!m_href(k + 1, nfr)) return 1'b0;
    return (((k + 1) % L) % 2) == 0;
  endfunction

  task automatic check_framing(input string tag, input int ncyc, input int nfr);
    int e_vs, e_hr, e_fd, e_rd;
    e_vs = 0; e_hr = 0; e_fd = 0; e_rd = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (tr_vs[c]  !== m_vs(c - 2, nfr))   e_vs++;
      if (tr_hr[c]  !== m_href(c - 2, nfr)) e_hr++;
      if (tr_fd[c]  !== m_fd(c - 2, nfr))   e_fd++;
      if (tr_rdy[c] !== m_rdy(c - 2, nfr))  e_rd++;
    end
    check({tag, " vsync trace errors"}, e_vs, 0);
    check({tag, " href trace errors"}, e_hr, 0);
    check({tag, " frame_done trace errors"}, e_fd, 0);
    check({tag, " ready trace errors"}, e_rd, 0);
  endtask

  // Run lengths of the first frame in the trace.
  task automatic measure(input string tag, input int ncyc);
    int t, a;
    t = 0;
    while (t < ncyc && tr_vs[t] !== 1'b1) t++;
    check({tag, " vsync start index"}, t, 2);
    a = t;
    while (t < ncyc && tr_vs[t] === 1'b1) t++;
    check({tag, " vsync length"}, t - a, 16);
    a = t;
    while (t < ncyc && tr_hr[t] !== 1'b1) t++;
    check({tag, " vsync-to-href gap"}, t - a, 32);
    a = t;
    while (t < ncyc && tr_hr[t] === 1'b1) t++;
    check({tag, " href length"}, t - a, 8);
    t = a;
    while (t < ncyc && tr_fd[t] !== 1'b1) t++;
    check({tag, " frame_done cycle of frame"}, t - 1, 96);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ncyc, cnt;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;

    vecs[0]  = '{12'hABC, 8'h0A, 8'hBC};
    vecs[1]  = '{12'h123, 8'h01, 8'h23};
    vecs[2]  = '{12'h456, 8'h04, 8'h56};
    vecs[3]  = '{12'h789, 8'h07, 8'h89};
    vecs[4]  = '{12'hFFF, 8'h0F, 8'hFF};
    vecs[5]  = '{12'h000, 8'h00, 8'h00};
    vecs[6]  = '{12'hF0F, 8'h0F, 8'h0F};
    vecs[7]  = '{12'h0F0, 8'h00, 8'hF0};
    vecs[8]  = '{12'hA5A, 8'h0A, 8'h5A};
    vecs[9]  = '{12'h5A5, 8'h05, 8'hA5};
    vecs[10] = '{12'h800, 8'h08, 8'h00};
    vecs[11] = '{12'h001, 8'h00, 8'h01};
    vecs[12] = '{12'hC3C, 8'h0C, 8'h3C};
    vecs[13] = '{12'h3C3, 8'h03, 8'hC3};
    vecs[14] = '{12'hDEF, 8'h0D, 8'hEF};
    vecs[15] = '{12'hE01, 8'h0E, 8'h01};

    // ---- A: idle, two frames, i_en dropped during row 1 of frame 2 ----
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (tr_vs[c] !== 1'b0 || tr_hr[c] !== 1'b0 || tr_fd[c] !== 1'b0 ||
          tr_rdy[c] !== 1'b0 || tr_ur[c] !== 1'b0) cnt++;
    end
    check("idle outputs active", cnt, 0);
    cyc = 0;
    for (int i = 0; i < 16; i++) src_q.push_back(i);
    en_drv = 1'b1;
    ncyc = 2 + 2 * FRAME + 40;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 2 + FRAME + 66) en_drv = 1'b0;
      tick();
    end
    check_framing("A", ncyc, 2);
    measure("A", ncyc);
    check("A vsync right after frame_done", {30'h0, tr_fd[97], tr_vs[98]}, 32'h3);
    cnt = 0;
    for (int c = 0; c < ncyc; c++) if (tr_fd[c] === 1'b1) cnt++;
    check("A frame_done pulses", cnt, 2);
    check("A handshakes", n_hs, 16);
    check("A pixels left unsent", exp_q.size(), 0);
    check("A nonzero byte outside href", zero_viol, 0);
    cnt = 0;
    for (int c = 0; c < ncyc; c++) if (tr_ur[c] !== 1'b0) cnt++;
    check("A underrun cycles", cnt, 0);
    check("A state after en drop", {29'h0, dbg_state}, {29'h0, IDLE});

    // ---- B: second pixel of row 0 starved ----
    do_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(i);
    starve_idx = 1;
    en_drv = 1'b1;
    ncyc = 2 + FRAME + 20;
    for (int c = 0; c < ncyc; c++) tick();
    check_framing("B", ncyc, 2);
    cnt = 0;
    for (int c = 0; c < ncyc; c++) if (tr_ur[c] !== ((c >= 52) && (c < 98))) cnt++;
    check("B underrun trace errors", cnt, 0);
    check("B underrun edges", {28'h0, tr_ur[51], tr_ur[52], tr_ur[97], tr_ur[98]}, 32'h6);
    check("B handshakes", n_hs, 8);
    check("B pixels left unsent", exp_q.size(), 0);
    check("B source entries left", src_q.size(), 1);
    check("B nonzero byte outside href", zero_viol, 0);

    // ---- D: reset during ACTIVE, then restart ----
    do_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(i);
    en_drv = 1'b1;
    for (int c = 0; c < 53; c++) tick();
    check("D href before reset", {31'h0, href}, 1);
    rst = 1'b1;
    #1;
    check("D async reset: href/vsync", {30'h0, href, vsync}, 0);
    check("D async reset: pix_byte", {24'h0, pix_byte}, 0);
    check("D async reset: ready/frame_done/underrun", {29'h0, ready, fdone, underrun}, 0);
    check("D async reset: state", {29'h0, dbg_state}, {29'h0, IDLE});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    exp_q.delete();
    src_q.delete();
    n_hs = 0;
    mon_phase = 1'b0;
    zero_viol = 0;
    for (int i = 8; i < 16; i++) src_q.push_back(i);
    ncyc = 2 + FRAME + 2;
    for (int c = 0; c < ncyc; c++) tick();
    check_framing("D", ncyc, 2);
    measure("D", ncyc);
    check("D handshakes", n_hs, 8);
    check("D pixels left unsent", exp_q.size(), 0);
    check("D nonzero byte outside href", zero_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
